ibex_avalon_lsu_bridge: RTL and testbench
=========================================

IBEX_AVALON_LSU_BRIDGE -- requirements
Module: ibex_avalon_lsu_bridge

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, the address width on both sides.
REQ-002 SHALL have parameter DataWidth, default 32, the data width; DataWidth/8 is the byte-enable width.
REQ-003 SHALL have parameter MaxOutstanding, default 2, the number of accepted but not-yet-responded transactions (1..16).
REQ-004 SHALL have parameter WordAddr, default 1; when 1, the Avalon address is the core address shifted right by log2(DataWidth/8) and zero-filled.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk_i input 1 is the clock; rst_ni input 1 is the reset.
REQ-006 SHALL have these core-side ports: data_req_i in 1; data_we_i in 1; data_be_i in DataWidth/8; data_addr_i in AddrWidth; data_wdata_i in DataWidth; data_gnt_o out 1; data_rvalid_o out 1; data_rdata_o out DataWidth; data_err_o out 1.
REQ-007 SHALL have these Avalon-side ports: avm_address out AddrWidth; avm_byteenable out DataWidth/8; avm_read out 1; avm_write out 1; avm_writedata out DataWidth; avm_readdata in DataWidth; avm_waitrequest in 1; avm_readdatavalid in 1; avm_response in 2.
REQ-008 SHALL have these status ports: outstanding_o out clog2(MaxOutstanding+1), the current count of pending transactions; protocol_err_o out 1, sticky.

Function
REQ-009 SHALL issue Avalon commands combinationally: avm_read = req & ~we & ~full, and avm_write = req & we & ~full; address, byteenable and writedata SHALL pass through (address translated per REQ-004).
REQ-010 SHALL assert data_gnt_o = data_req_i & ~avm_waitrequest & ~full, in the same cycle as the command is accepted.
REQ-011 SHALL treat full as count == MaxOutstanding, evaluated on the registered count; a same-cycle pop SHALL NOT unblock a new issue.
REQ-012 SHALL push one entry {is_write} into an in-order tracking FIFO on every grant.
REQ-013 SHALL pop a read entry at the head on avm_readdatavalid; the next cycle it SHALL register data_rvalid_o=1, data_rdata_o=avm_readdata, and data_err_o=(avm_response != OKAY).
REQ-014 SHALL pop a write entry in the first cycle it is at the head; the next cycle it SHALL assert data_rvalid_o=1 with data_rdata_o=0 and data_err_o=0, so that an idle write has 2-cycle grant-to-rvalid latency.
REQ-015 SHALL return responses strictly in grant order, so a write behind a pending read SHALL wait for that read's readdatavalid.
REQ-016 SHALL set protocol_err_o on avm_readdatavalid when the FIFO is empty or its head is a write; in that case it SHALL produce no rvalid, leave the FIFO unchanged, and clear the flag only on reset.
REQ-017 SHALL allow a simultaneous push and pop in the same cycle, leaving the count unchanged; the FIFO pointers SHALL wrap modulo MaxOutstanding.
REQ-018 SHALL hold data_rdata_o at its last value when data_rvalid_o=0.
REQ-019 SHALL keep outstanding_o equal to the registered count, which is pushes minus pops since reset.

Reset
REQ-020 SHALL, while rst_ni=0, clear the count, pointers, data_rvalid_o, data_rdata_o, data_err_o and protocol_err_o to 0, and force avm_read, avm_write and data_gnt_o to 0.
REQ-021 SHALL discard in-flight transactions on a mid-operation reset; a readdatavalid arriving after reset release SHALL set protocol_err_o.

Structure
REQ-022 SHALL place in package ibex_avalon_pkg: the avalon_resp_e enum (OKAY=2'b00, RESERVED=2'b01, SLVERR=2'b10, DECERR=2'b11) and the tracking-entry typedef.
REQ-023 SHALL implement the tracking FIFO as sub-module ibex_avalon_txn_fifo, parameterised by depth and entry type, with push, pop, full, empty, head and count.

Verification
REQ-024 SHALL cover this scenario: a single read to byte address 0x100 with WordAddr=1 and readdatavalid 3 cycles later with data 0xDEADBEEF -> avm_address=0x40, grant in cycle 0, and rvalid with 0xDEADBEEF one cycle after readdatavalid.
REQ-025 SHALL cover this scenario: waitrequest held high for 4 cycles on a write -> avm_write held for those 4 cycles, gnt in cycle 4 only, and rvalid 2 cycles after gnt.
REQ-026 SHALL cover this scenario: MaxOutstanding=2 with three back-to-back reads and delayed readdatavalid -> third gnt withheld until the cycle after the first readdatavalid, and outstanding_o peaks at 2.
REQ-027 SHALL cover this scenario: a read then a write, with the read response delayed 5 cycles -> write rvalid follows the read rvalid by exactly 1 cycle.
REQ-028 SHALL cover this scenario: a read answered with avm_response=2'b10 -> rvalid with data_err_o=1; a spurious readdatavalid while empty -> protocol_err_o=1 sticky and no rvalid.
REQ-029 SHALL cover this scenario: rst_ni dropped with 2 reads outstanding -> outstanding_o=0 and outputs cleared immediately; after release, a late readdatavalid sets protocol_err_o.

Source files
------------

// File: rtl/ibex_avalon_lsu_bridge_pkg.sv
// ibex_avalon_pkg: shared types for the Ibex LSU to Avalon-MM bridge.
//   avalon_resp_e : Avalon response codes carried on avm_response
//   txn_entry_t   : one in-order tracking entry per granted transaction
package ibex_avalon_pkg;

    typedef enum logic [1:0] {
        OKAY     = 2'b00,
        RESERVED = 2'b01,
        SLVERR   = 2'b10,
        DECERR   = 2'b11
    } avalon_resp_e;

    typedef struct packed {
        logic is_write;
    } txn_entry_t;

endpackage

// File: rtl/ibex_avalon_lsu_bridge_if.sv
// Bus interfaces for the LSU bridge.
//   ibex_lsu_if : Ibex data-side request/grant/rvalid channel.
//                 master = core, slave = bridge.
//   ibex_avm_if : Avalon-MM pipelined master channel.
//                 master = bridge, slave = memory/interconnect.
// Signal names keep the bridge-side port names so they trace to the block ports.
interface ibex_lsu_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic                   data_req_i;
    logic                   data_we_i;
    logic [DataWidth/8-1:0] data_be_i;
    logic [AddrWidth-1:0]   data_addr_i;
    logic [DataWidth-1:0]   data_wdata_i;
    logic                   data_gnt_o;
    logic                   data_rvalid_o;
    logic [DataWidth-1:0]   data_rdata_o;
    logic                   data_err_o;

    modport master (
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );
    modport slave (
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );
endinterface

interface ibex_avm_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic [AddrWidth-1:0]   avm_address;
    logic [DataWidth/8-1:0] avm_byteenable;
    logic                   avm_read;
    logic                   avm_write;
    logic [DataWidth-1:0]   avm_writedata;
    logic [DataWidth-1:0]   avm_readdata;
    logic                   avm_waitrequest;
    logic                   avm_readdatavalid;
    logic [1:0]             avm_response;

    modport master (
        output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest, avm_readdatavalid, avm_response
    );
    modport slave (
        input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest, avm_readdatavalid, avm_response
    );
endinterface

// File: rtl/ibex_avalon_lsu_bridge_txn_fifo.sv
// ibex_avalon_txn_fifo: in-order tracking FIFO for granted transactions.
//   push_i/push_data_i : enqueue (ignored when full)
//   pop_i              : dequeue head (ignored when empty)
//   head_o             : entry at the head, valid when !empty_o
//   full_o/empty_o/count_o : registered occupancy
// Pointers wrap modulo Depth, so Depth need not be a power of two.
module ibex_avalon_txn_fifo #(
    parameter int  Depth   = 2,
    parameter type entry_t = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  entry_t                     push_data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output entry_t                     head_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);
    localparam int CntW = $clog2(Depth + 1);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    entry_t            mem_q [Depth];
    logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

    always_comb begin
        wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = do_pop  ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ibex_avalon_lsu_bridge.sv
// ibex_avalon_lsu_bridge: Ibex LSU data port to Avalon-MM pipelined master.
//   clk_i, rst_ni  : clock, async active-low reset
//   core           : Ibex data channel (req/gnt/rvalid)
//   avm            : Avalon-MM master channel
//   outstanding_o  : granted transactions awaiting a response
//   protocol_err_o : sticky, set by readdatavalid with no read pending at the head
// Commands issue combinationally; responses leave in grant order one cycle after
// their pop. Writes complete locally as soon as they reach the tracking head.
module ibex_avalon_lsu_bridge
    import ibex_avalon_pkg::*;
#(
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 2,
    parameter int WordAddr       = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    ibex_lsu_if.slave                           core,
    ibex_avm_if.master                          avm,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                                protocol_err_o
);
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam int OffW = $clog2(DataWidth / 8);

    logic            full, empty, issue, gnt;
    logic            rd_pop, wr_pop, pop, perr_set;
    txn_entry_t      head, push_entry;
    logic [CntW-1:0] count;

    logic                 rvalid_q, rvalid_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 perr_q, perr_d;

    // full comes from the registered count, so a pop this cycle cannot free a slot
    // for an issue in the same cycle. rst_ni gating keeps commands quiet in reset.
    assign full  = (count == CntW'(MaxOutstanding));
    assign issue = rst_ni & core.data_req_i & ~full;
    assign gnt   = issue & ~avm.avm_waitrequest;

    assign avm.avm_read       = issue & ~core.data_we_i;
    assign avm.avm_write      = issue &  core.data_we_i;
    assign avm.avm_address    = (WordAddr != 0) ? (core.data_addr_i >> OffW) : core.data_addr_i;
    assign avm.avm_byteenable = core.data_be_i;
    assign avm.avm_writedata  = core.data_wdata_i;
    assign core.data_gnt_o    = gnt;

    assign push_entry.is_write = core.data_we_i;

    // Reads leave on readdatavalid; a write at the head leaves unconditionally.
    assign rd_pop   = avm.avm_readdatavalid & ~empty & ~head.is_write;
    assign wr_pop   = ~empty & head.is_write;
    assign pop      = rd_pop | wr_pop;
    assign perr_set = avm.avm_readdatavalid & (empty | head.is_write);

    ibex_avalon_txn_fifo #(
        .Depth   (MaxOutstanding),
        .entry_t (txn_entry_t)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (gnt),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .full_o      (),
        .empty_o     (empty),
        .head_o      (head),
        .count_o     (count)
    );

    always_comb begin
        rvalid_d = pop;
        rdata_d  = rdata_q;
        err_d    = err_q;
        perr_d   = perr_q | perr_set;
        if (rd_pop) begin
            rdata_d = avm.avm_readdata;
            err_d   = (avalon_resp_e'(avm.avm_response) != OKAY);
        end else if (wr_pop) begin
            rdata_d = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            perr_q   <= perr_d;
        end
    end

    assign core.data_rvalid_o = rvalid_q;
    assign core.data_rdata_o  = rdata_q;
    assign core.data_err_o    = err_q;
    assign outstanding_o      = count;
    assign protocol_err_o     = perr_q;

endmodule

// File: tb/tb_ibex_avalon_lsu_bridge.sv
// Directed bench for ibex_avalon_lsu_bridge with default parameters
// (32-bit, MaxOutstanding=2, WordAddr=1). Inputs change 2ns after each rising
// edge and outputs are checked 1ns later, so registered outputs reflect the
// edge just passed and combinational outputs reflect the new inputs.
module tb_ibex_avalon_lsu_bridge;

    logic       clk_i  = 1'b0;
    logic       rst_ni = 1'b0;
    logic [1:0] outstanding_o;
    logic       protocol_err_o;
    int         n_cmp = 0;
    int         n_err = 0;

    ibex_lsu_if #(.AddrWidth(32), .DataWidth(32)) u_lsu ();
    ibex_avm_if #(.AddrWidth(32), .DataWidth(32)) u_avm ();

    ibex_avalon_lsu_bridge #(
        .AddrWidth      (32),
        .DataWidth      (32),
        .MaxOutstanding (2),
        .WordAddr       (1)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .core           (u_lsu),
        .avm            (u_avm),
        .outstanding_o  (outstanding_o),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle();
        u_lsu.data_req_i          = 1'b0;
        u_lsu.data_we_i           = 1'b0;
        u_lsu.data_be_i           = 4'hF;
        u_lsu.data_addr_i         = '0;
        u_lsu.data_wdata_i        = '0;
        u_avm.avm_readdata        = '0;
        u_avm.avm_waitrequest     = 1'b0;
        u_avm.avm_readdatavalid   = 1'b0;
        u_avm.avm_response        = 2'b00;
    endtask

    task automatic rd(input logic [31:0] addr);
        u_lsu.data_req_i  = 1'b1;
        u_lsu.data_we_i   = 1'b0;
        u_lsu.data_addr_i = addr;
    endtask

    task automatic rdv(input logic [31:0] data, input logic [1:0] resp);
        u_avm.avm_readdatavalid = 1'b1;
        u_avm.avm_readdata      = data;
        u_avm.avm_response      = resp;
    endtask

    initial begin
        idle();

        // reset state, with a request present that must be masked
        nxt(); rd(32'h100); #1;
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_rvalid", u_lsu.data_rvalid_o, 0);
        chk("rst_rdata", u_lsu.data_rdata_o, 0);
        chk("rst_err", u_lsu.data_err_o, 0);
        chk("rst_perr", protocol_err_o, 0);
        chk("rst_avm_read", u_avm.avm_read, 0);
        chk("rst_gnt", u_lsu.data_gnt_o, 0);
        nxt(); idle(); rst_ni = 1'b1;

        // single read, address translation, rdv three cycles after grant
        nxt(); rd(32'h100); #1;
        chk("r1_gnt", u_lsu.data_gnt_o, 1);
        chk("r1_read", u_avm.avm_read, 1);
        chk("r1_write", u_avm.avm_write, 0);
        chk("r1_addr", u_avm.avm_address, 32'h40);
        chk("r1_be", u_avm.avm_byteenable, 4'hF);
        nxt(); idle(); #1;
        chk("r1_out1", outstanding_o, 1);
        chk("r1_gnt_idle", u_lsu.data_gnt_o, 0);
        nxt(); #1;
        chk("r1_rvalid_c2", u_lsu.data_rvalid_o, 0);
        nxt(); rdv(32'hDEADBEEF, 2'b00); #1;
        chk("r1_rvalid_c3", u_lsu.data_rvalid_o, 0);
        nxt(); idle(); #1;
        chk("r1_rvalid", u_lsu.data_rvalid_o, 1);
        chk("r1_rdata", u_lsu.data_rdata_o, 32'hDEADBEEF);
        chk("r1_err", u_lsu.data_err_o, 0);
        chk("r1_out0", outstanding_o, 0);
        nxt(); #1;
        chk("r1_rvalid_drop", u_lsu.data_rvalid_o, 0);
        chk("r1_rdata_hold", u_lsu.data_rdata_o, 32'hDEADBEEF);

        // write stalled by waitrequest for four cycles
        nxt();
        u_lsu.data_req_i = 1'b1; u_lsu.data_we_i = 1'b1; u_lsu.data_addr_i = 32'h8;
        u_lsu.data_be_i = 4'h3; u_lsu.data_wdata_i = 32'hA5A51234;
        u_avm.avm_waitrequest = 1'b1; #1;
        chk("w_addr", u_avm.avm_address, 32'h2);
        chk("w_wdata", u_avm.avm_writedata, 32'hA5A51234);
        chk("w_be", u_avm.avm_byteenable, 4'h3);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) begin nxt(); #1; end
            chk("w_write_stall", u_avm.avm_write, 1);
            chk("w_gnt_stall", u_lsu.data_gnt_o, 0);
        end
        nxt(); u_avm.avm_waitrequest = 1'b0; #1;
        chk("w_gnt_c4", u_lsu.data_gnt_o, 1);
        chk("w_write_c4", u_avm.avm_write, 1);
        nxt(); idle(); #1;
        chk("w_out1", outstanding_o, 1);
        chk("w_rvalid_c5", u_lsu.data_rvalid_o, 0);
        nxt(); #1;
        chk("w_rvalid_c6", u_lsu.data_rvalid_o, 1);
        chk("w_rdata", u_lsu.data_rdata_o, 0);
        chk("w_err", u_lsu.data_err_o, 0);
        chk("w_out0", outstanding_o, 0);

        // three back-to-back reads against a depth of two
        nxt(); rd(32'h200); #1;
        chk("f_gnt0", u_lsu.data_gnt_o, 1);
        nxt(); rd(32'h204); #1;
        chk("f_gnt1", u_lsu.data_gnt_o, 1);
        nxt(); rd(32'h208); #1;
        chk("f_out2", outstanding_o, 2);
        chk("f_gnt2_blocked", u_lsu.data_gnt_o, 0);
        chk("f_read2_blocked", u_avm.avm_read, 0);
        nxt(); rdv(32'h11111111, 2'b00); #1;
        chk("f_gnt_samecycle_pop", u_lsu.data_gnt_o, 0);
        nxt(); u_avm.avm_readdatavalid = 1'b0; #1;
        chk("f_gnt2", u_lsu.data_gnt_o, 1);
        chk("f_addr2", u_avm.avm_address, 32'h82);
        chk("f_rdata0", u_lsu.data_rdata_o, 32'h11111111);
        chk("f_out_after_pop", outstanding_o, 1);
        nxt(); idle(); rdv(32'h22222222, 2'b00); #1;
        chk("f_out_peak", outstanding_o, 2);
        nxt(); rdv(32'h33333333, 2'b00); #1;
        chk("f_rdata1", u_lsu.data_rdata_o, 32'h22222222);
        nxt(); idle(); #1;
        chk("f_rdata2", u_lsu.data_rdata_o, 32'h33333333);
        chk("f_rvalid2", u_lsu.data_rvalid_o, 1);
        chk("f_out_end", outstanding_o, 0);

        // write ordered behind a slow read
        nxt(); rd(32'h10); #1;
        chk("o_gnt_rd", u_lsu.data_gnt_o, 1);
        nxt(); u_lsu.data_we_i = 1'b1; u_lsu.data_addr_i = 32'h14; #1;
        chk("o_gnt_wr", u_lsu.data_gnt_o, 1);
        for (int c = 2; c <= 4; c++) begin
            nxt(); idle(); #1;
            chk("o_wait_rvalid", u_lsu.data_rvalid_o, 0);
        end
        nxt(); rdv(32'hCAFEF00D, 2'b00); #1;
        chk("o_wait_rvalid_c5", u_lsu.data_rvalid_o, 0);
        nxt(); idle(); #1;
        chk("o_rd_rvalid", u_lsu.data_rvalid_o, 1);
        chk("o_rd_rdata", u_lsu.data_rdata_o, 32'hCAFEF00D);
        chk("o_out_wr_left", outstanding_o, 1);
        nxt(); #1;
        chk("o_wr_rvalid", u_lsu.data_rvalid_o, 1);
        chk("o_wr_rdata", u_lsu.data_rdata_o, 0);
        chk("o_out0", outstanding_o, 0);
        nxt(); #1;
        chk("o_rvalid_drop", u_lsu.data_rvalid_o, 0);

        // error response, then a spurious readdatavalid
        nxt(); rd(32'h20); #1;
        chk("e_gnt", u_lsu.data_gnt_o, 1);
        nxt(); idle(); rdv(32'h00000BAD, 2'b10); #1;
        nxt(); idle(); #1;
        chk("e_rvalid", u_lsu.data_rvalid_o, 1);
        chk("e_err", u_lsu.data_err_o, 1);
        chk("e_rdata", u_lsu.data_rdata_o, 32'hBAD);
        nxt(); rdv(32'h12345678, 2'b00); #1;
        chk("p_perr_before", protocol_err_o, 0);
        nxt(); idle(); #1;
        chk("p_perr_set", protocol_err_o, 1);
        chk("p_no_rvalid", u_lsu.data_rvalid_o, 0);
        chk("p_out0", outstanding_o, 0);
        chk("p_rdata_hold", u_lsu.data_rdata_o, 32'hBAD);
        nxt(); nxt(); #1;
        chk("p_perr_sticky", protocol_err_o, 1);

        // reset with two reads outstanding, then a late readdatavalid
        nxt(); rd(32'h300); #1;
        chk("x_gnt0", u_lsu.data_gnt_o, 1);
        nxt(); rd(32'h304); rdv(32'h5555, 2'b11); #1;
        chk("x_gnt1_push_pop", u_lsu.data_gnt_o, 1);
        nxt(); rd(32'h308); u_avm.avm_readdatavalid = 1'b0; #1;
        chk("x_out_push_pop", outstanding_o, 1);
        chk("x_err_decerr", u_lsu.data_err_o, 1);
        chk("x_gnt2", u_lsu.data_gnt_o, 1);
        nxt(); idle(); #1;
        chk("x_out2", outstanding_o, 2);
        rst_ni = 1'b0; rd(32'h30C); #1;
        chk("x_rst_out", outstanding_o, 0);
        chk("x_rst_rdata", u_lsu.data_rdata_o, 0);
        chk("x_rst_err", u_lsu.data_err_o, 0);
        chk("x_rst_rvalid", u_lsu.data_rvalid_o, 0);
        chk("x_rst_perr", protocol_err_o, 0);
        chk("x_rst_gnt", u_lsu.data_gnt_o, 0);
        chk("x_rst_read", u_avm.avm_read, 0);
        nxt(); idle(); rst_ni = 1'b1; #1;
        chk("x_rel_out", outstanding_o, 0);
        nxt(); rdv(32'h7777, 2'b00); #1;
        nxt(); idle(); #1;
        chk("x_late_perr", protocol_err_o, 1);
        chk("x_late_no_rvalid", u_lsu.data_rvalid_o, 0);
        chk("x_late_out", outstanding_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
